// File: rtl/acc_pkg.sv
// Shared types and default sizing for the accumulator core and its multiplier.
package acc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [3:0] {
        OP_MOV  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADDC = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_IOR  = 4'h5,
        OP_XOR  = 4'h6,
        OP_INC  = 4'h7,
        OP_DEC  = 4'h8,
        OP_RLC  = 4'h9,
        OP_RRC  = 4'hA,
        OP_CLR  = 4'hB,
        OP_MUL  = 4'hC,
        OP_NOP  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_LOOP = 2'd1,
        ST_MUL_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/acc_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles.
module acc_mul
    import acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_q;

endmodule

// File: rtl/acc_core.sv
// Accumulator core with a W register, register file, carry/zero flags and a multi-cycle MUL.
// state       | meaning
// ST_IDLE     | accepting instructions; single-cycle ops retire here
// ST_MUL_LOOP | multiplier iterating, one partial product per cycle
// ST_MUL_WB   | product written to dest/prodh, done pulsed
module acc_core
    import acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [3:0]               op,
    input  logic                     d,
    input  logic                     src_lit,
    input  logic [WIDTH-1:0]         k,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         w,
    output logic                     carry,
    output logic                     zero,
    output logic [WIDTH-1:0]         prodh,
    output logic [WIDTH-1:0]         result,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] prodh_q, prodh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             mdst_q, mdst_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic [WIDTH-1:0] file_q [DEPTH];

    logic             file_we;
    logic [AW-1:0]    file_waddr;
    logic [WIDTH-1:0] file_wdata;

    logic             accept;
    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_wr;

    logic               mul_start;
    logic               mul_busy;
    logic [2*WIDTH-1:0] mul_prod;

    assign accept = inst_valid && (state_q == ST_IDLE);
    assign src    = src_lit ? k : file_q[addr];

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = carry_q;
        alu_wr  = 1'b1;
        case (op_e'(op))
            OP_MOV:  alu_res = src;
            OP_ADD: begin
                wide    = {1'b0, w_q} + {1'b0, src};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_ADDC: begin
                wide    = {1'b0, w_q} + {1'b0, src} + {{WIDTH{1'b0}}, carry_q};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SUB: begin
                // Borrow appears in the extra bit; carry is its inverse.
                wide    = {1'b0, src} - {1'b0, w_q};
                alu_res = wide[WIDTH-1:0];
                alu_c   = ~wide[WIDTH];
            end
            OP_AND:  alu_res = w_q & src;
            OP_IOR:  alu_res = w_q | src;
            OP_XOR:  alu_res = w_q ^ src;
            OP_INC:  alu_res = src + 1'b1;
            OP_DEC:  alu_res = src - 1'b1;
            OP_RLC: begin
                alu_res = {src[WIDTH-2:0], carry_q};
                alu_c   = src[WIDTH-1];
            end
            OP_RRC: begin
                alu_res = {carry_q, src[WIDTH-1:1]};
                alu_c   = src[0];
            end
            OP_CLR:  alu_res = '0;
            default: alu_wr  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        prodh_d    = prodh_q;
        result_d   = result_q;
        done_d     = 1'b0;
        mdst_d     = mdst_q;
        maddr_d    = maddr_q;
        file_we    = 1'b0;
        file_waddr = addr;
        file_wdata = alu_res;
        mul_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e'(op) == OP_MUL) begin
                        mul_start = 1'b1;
                        mdst_d    = d;
                        maddr_d   = addr;
                        cnt_d     = '0;
                        state_d   = ST_MUL_LOOP;
                    end else begin
                        done_d = 1'b1;
                        if (alu_wr) begin
                            if (d) file_we = 1'b1;
                            else   w_d     = alu_res;
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            carry_d  = alu_c;
                        end
                    end
                end
            end
            ST_MUL_LOOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1) || !mul_busy) begin
                    state_d = ST_MUL_WB;
                end
            end
            ST_MUL_WB: begin
                file_waddr = maddr_q;
                file_wdata = mul_prod[WIDTH-1:0];
                if (mdst_q) file_we = 1'b1;
                else        w_d     = mul_prod[WIDTH-1:0];
                prodh_d  = mul_prod[2*WIDTH-1:WIDTH];
                carry_d  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                zero_d   = (mul_prod[WIDTH-1:0] == '0);
                result_d = mul_prod[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            w_q      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            prodh_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            mdst_q   <= 1'b0;
            maddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            prodh_q  <= prodh_d;
            result_q <= result_d;
            done_q   <= done_d;
            mdst_q   <= mdst_d;
            maddr_q  <= maddr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                file_q[i] <= '0;
            end
        end else if (file_we) begin
            file_q[file_waddr] <= file_wdata;
        end
    end

    acc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (w_q),
        .b       (src),
        .busy    (mul_busy),
        .product (mul_prod)
    );

    assign inst_ready = (state_q == ST_IDLE);
    assign w          = w_q;
    assign carry      = carry_q;
    assign zero       = zero_q;
    assign prodh      = prodh_q;
    assign result     = result_q;
    assign done       = done_q;

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: an 8-bit/16-entry instance and a 16-bit/4-entry instance.
module tb_acc_core;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       v8 = 1'b0, d8 = 1'b0, sl8 = 1'b0;
    logic [3:0] op8 = 4'h0, a8 = 4'h0;
    logic [7:0] k8 = 8'h0;
    logic       rdy8, c8, z8, dn8;
    logic [7:0] w8, ph8, r8;

    logic        v16 = 1'b0, d16 = 1'b0, sl16 = 1'b0;
    logic [3:0]  op16 = 4'h0;
    logic [1:0]  a16 = 2'h0;
    logic [15:0] k16 = 16'h0;
    logic        rdy16, c16, z16, dn16;
    logic [15:0] w16, ph16, r16;

    int checks = 0;
    int errors = 0;

    acc_core #(.WIDTH(8), .DEPTH(16)) u_dut8 (
        .clk(clk), .reset(reset), .inst_valid(v8), .inst_ready(rdy8), .op(op8),
        .d(d8), .src_lit(sl8), .k(k8), .addr(a8), .w(w8), .carry(c8), .zero(z8),
        .prodh(ph8), .result(r8), .done(dn8)
    );

    acc_core #(.WIDTH(16), .DEPTH(4)) u_dut16 (
        .clk(clk), .reset(reset), .inst_valid(v16), .inst_ready(rdy16), .op(op16),
        .d(d16), .src_lit(sl16), .k(k16), .addr(a16), .w(w16), .carry(c16), .zero(z16),
        .prodh(ph16), .result(r16), .done(dn16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction, returns 1ns after the accepting edge.
    task automatic issue8(input logic [3:0] o, input logic dd, input logic sl,
                          input logic [7:0] kk, input logic [3:0] aa);
        @(negedge clk);
        op8 = o; d8 = dd; sl8 = sl; k8 = kk; a8 = aa; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] o, input logic dd, input logic sl,
                           input logic [15:0] kk, input logic [1:0] aa);
        @(negedge clk);
        op16 = o; d16 = dd; sl16 = sl; k16 = kk; a16 = aa; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    int lowcnt;
    int seen;
    int dones;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w", w8, 0);
        chk("rst_carry", c8, 0);
        chk("rst_zero", z8, 0);
        chk("rst_prodh", ph8, 0);
        chk("rst_result", r8, 0);
        chk("rst_done", dn8, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", rdy8, 1);

        issue8(OP_MOV, 0, 1, 8'd10, 0);
        chk("mov_w", w8, 10);
        chk("mov_zero", z8, 0);
        chk("mov_done", dn8, 1);
        @(posedge clk); #1;
        chk("mov_done_pulse", dn8, 0);

        issue8(OP_MOV, 0, 1, 8'd200, 0);
        issue8(OP_ADD, 0, 1, 8'd100, 0);
        chk("add_w", w8, 44);
        chk("add_carry", c8, 1);
        issue8(OP_ADDC, 0, 1, 8'd0, 0);
        chk("addc_w", w8, 45);
        chk("addc_carry", c8, 0);

        issue8(OP_MOV, 0, 1, 8'd5, 0);
        issue8(OP_MOV, 1, 1, 8'd5, 3);
        chk("movf_result", r8, 5);
        chk("movf_w_kept", w8, 5);
        issue8(OP_SUB, 1, 0, 8'd0, 3);
        chk("sub_eq_result", r8, 0);
        chk("sub_eq_zero", z8, 1);
        chk("sub_eq_carry", c8, 1);
        chk("sub_eq_w_kept", w8, 5);
        issue8(OP_SUB, 1, 0, 8'd0, 3);
        chk("sub_borrow_result", r8, 251);
        chk("sub_borrow_carry", c8, 0);
        chk("sub_borrow_zero", z8, 0);
        issue8(OP_MOV, 0, 0, 8'd0, 3);
        chk("file3_readback", w8, 251);

        issue8(OP_MOV, 0, 1, 8'h0F, 0);
        issue8(OP_AND, 0, 1, 8'h3C, 0);
        chk("and_w", w8, 8'h0C);
        issue8(OP_IOR, 0, 1, 8'h30, 0);
        chk("ior_w", w8, 8'h3C);
        issue8(OP_XOR, 0, 1, 8'h3C, 0);
        chk("xor_w", w8, 0);
        chk("xor_zero", z8, 1);
        issue8(OP_DEC, 0, 1, 8'h00, 0);
        chk("dec_wrap_w", w8, 8'hFF);
        chk("dec_carry_kept", c8, 0);
        issue8(OP_RLC, 0, 1, 8'h81, 0);
        chk("rlc_w", w8, 8'h02);
        chk("rlc_carry", c8, 1);
        issue8(OP_RRC, 0, 1, 8'h02, 0);
        chk("rrc_w", w8, 8'h81);
        chk("rrc_carry", c8, 0);
        issue8(OP_NOP, 0, 1, 8'h00, 0);
        chk("nop_done", dn8, 1);
        chk("nop_w_kept", w8, 8'h81);
        chk("nop_result_kept", r8, 8'h81);

        // MUL 13*20 = 260: low 4, high 1; a CLR held during busy must be ignored.
        issue8(OP_MOV, 0, 1, 8'd13, 0);
        issue8(OP_MUL, 0, 1, 8'd20, 0);
        lowcnt = 0; seen = 0;
        if (!rdy8) lowcnt++;
        op8 = OP_CLR; k8 = 8'd0; v8 = 1'b1;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (dn8) seen = 1;
            if (!rdy8) lowcnt++;
        end
        v8 = 1'b0;
        chk("mul_done_seen", seen, 1);
        chk("mul_ready_low_cycles", lowcnt, 9);
        chk("mul_w", w8, 4);
        chk("mul_prodh", ph8, 1);
        chk("mul_carry", c8, 1);
        chk("mul_result", r8, 4);
        @(posedge clk); #1;
        chk("mul_done_pulse", dn8, 0);
        chk("mul_busy_clr_ignored", w8, 4);

        issue8(OP_MUL, 0, 1, 8'd3, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #2;
        chk("abort_w", w8, 0);
        chk("abort_carry", c8, 0);
        chk("abort_zero", z8, 0);
        chk("abort_prodh", ph8, 0);
        chk("abort_result", r8, 0);
        chk("abort_done", dn8, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", rdy8, 1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dn8) dones++;
        end
        chk("abort_no_done", dones, 0);
        issue8(OP_MOV, 0, 0, 8'd0, 3);
        chk("abort_file_cleared", w8, 0);
        chk("abort_file_zero", z8, 1);

        issue16(OP_MOV, 0, 1, 16'hFFFF, 0);
        issue16(OP_ADD, 0, 1, 16'h0001, 0);
        chk("w16_add_w", w16, 0);
        chk("w16_add_carry", c16, 1);
        issue16(OP_MOV, 0, 1, 16'hFFFF, 0);
        chk("w16_mov_w", w16, 16'hFFFF);
        issue16(OP_INC, 0, 1, 16'hFFFF, 0);
        chk("w16_inc_w", w16, 0);
        chk("w16_inc_zero", z16, 1);
        chk("w16_inc_carry_kept", c16, 1);
        issue16(OP_ADD, 0, 1, 16'h0000, 0);
        chk("w16_clear_carry", c16, 0);
        issue16(OP_RRC, 0, 1, 16'h0001, 0);
        chk("w16_rrc_w", w16, 0);
        chk("w16_rrc_carry", c16, 1);
        chk("w16_rrc_zero", z16, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal 4..32).
REQ-002 SHALL have parameter DEPTH, default 16, number of file registers (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port inst_valid  input  1  instruction present this cycle.
REQ-006 SHALL have port inst_ready  output  1  core can accept an instruction this cycle.
REQ-007 SHALL have port op  input  4  opcode.
REQ-008 SHALL have port d  input  1  destination select: 0 = W, 1 = file[addr].
REQ-009 SHALL have port src_lit  input  1  source select: 1 = literal k, 0 = file[addr].
REQ-010 SHALL have port k  input  WIDTH  literal operand.
REQ-011 SHALL have port addr  input  $clog2(DEPTH)  file register address.
REQ-012 SHALL have port w  output  WIDTH  working register.
REQ-013 SHALL have ports carry, zero  output  1 each  status flags.
REQ-014 SHALL have port prodh  output  WIDTH  high half of last MUL product.
REQ-015 SHALL have port result  output  WIDTH  value last written back.
REQ-016 SHALL have port done  output  1  one-cycle pulse on the cycle result/dest update becomes visible.

Function
REQ-017 An instruction SHALL be accepted on a rising edge where inst_valid and inst_ready are both 1; all operand/control inputs sampled at that edge only.
REQ-018 Opcodes SHALL be: 0 MOV, 1 ADD, 2 ADDC, 3 SUB, 4 AND, 5 IOR, 6 XOR, 7 INC, 8 DEC, 9 RLC, A RRC, B CLR, C MUL, D-F NOP; S = selected source, all ops read W and S.
REQ-019 ADD/ADDC SHALL compute W+S(+carry) at WIDTH+1 bits; low WIDTH bits to dest, bit WIDTH to carry.
REQ-020 SUB SHALL compute S-W; carry = 1 when no borrow (S >= W).
REQ-021 RLC/RRC SHALL rotate S through carry by one bit; INC/DEC/AND/IOR/XOR/MOV/CLR SHALL leave carry unchanged; INC/DEC wrap modulo 2^WIDTH.
REQ-022 zero SHALL be set to (written value == 0) for every op except NOP; NOP changes no state and still pulses done.
REQ-023 Single-cycle ops SHALL update dest, flags, result and pulse done at the edge after acceptance (latency 1); inst_ready stays 1, allowing back-to-back issue.
REQ-024 MUL SHALL be unsigned shift-add W*S over exactly WIDTH iteration cycles, then one writeback cycle: low half to dest, high half to prodh, carry = (high half != 0); latency WIDTH+1.
REQ-025 State machine SHALL be IDLE -> (MUL accepted) MUL_LOOP -> (iteration count == WIDTH-1) MUL_WB -> IDLE; inst_ready = 1 only in IDLE.
REQ-026 inst_valid while inst_ready = 0 SHALL be ignored with no side effect.
REQ-027 An instruction accepted the cycle after a writeback SHALL see the updated W, file and carry (no hazard).
REQ-028 Operands for MUL SHALL be latched at acceptance; later changes to inputs do not affect the product.

Reset
REQ-029 While reset = 0: w, carry, zero, prodh, result, all file registers = 0; done = 0; state = IDLE; inst_ready = 1 after release.
REQ-030 Reset asserted mid-MUL SHALL abort it immediately with no dest write; no done pulse afterward.

Structure
REQ-031 Opcode enum, state enum and default WIDTH/DEPTH constants SHALL live in shared package acc_pkg.
REQ-032 The MUL iteration datapath SHALL be a sub-module acc_mul (start, latched operands in; busy, product out).

Verification
REQ-033 Reset, then MOV k=10 d=0 src_lit=1 -> next edge w=10, zero=0, done=1 for one cycle.
REQ-034 w=200, ADD k=100 -> w=44, carry=1; then ADDC k=0 -> w=45, carry=0.
REQ-035 w=5, SUB src=file[3]=5 d=1 -> file[3]=0, zero=1, carry=1; SUB with file[3]=0 -> carry=0, file[3]=251.
REQ-036 w=13, MUL k=20 (WIDTH=8) -> inst_ready low 9 cycles, then w=4, prodh=1, carry=1, done pulse; inst_valid during busy ignored.
REQ-037 Start MUL, assert reset after 3 cycles -> all outputs 0, inst_ready=1 after release, no done.
REQ-038 WIDTH=16, DEPTH=4: w=0xFFFF, INC d=0 -> w=0, zero=1, carry unchanged; RRC k=1 with carry=0 -> w=0, carry=1.
